// File: rtl/data_stack_if.sv
// Decoder-to-operand-stack bus: stack controls and write data in, stack view and flags out.
interface data_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int DW = $clog2(DEPTH + 3);

  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] stk0;
  logic [WIDTH-1:0] stk1;
  logic [DW-1:0]    depth;
  logic             ovf;
  logic             udf;

  modport master (
    output data_in, load, push, pop,
    input  stk0, stk1, depth, ovf, udf
  );

  modport slave (
    input  data_in, load, push, pop,
    output stk0, stk1, depth, ovf, udf
  );
endinterface

// File: rtl/data_stack.sv
// Operand stack: top two entries in registers, deeper entries spilled to a DEPTH-entry RAM.
// Define DSTK_GUARD_EN for sticky ovf/udf flags that fully suppress the faulting push/pop.
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input logic         clk,
  input logic         rst,
  data_stack_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 3);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH + 2);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] stk0_q, stk0_d;
  logic [WIDTH-1:0] stk1_q, stk1_d;
  logic [SW-1:0]    sp_q, sp_d;
  logic [DW-1:0]    depth_q, depth_d;
`ifdef DSTK_GUARD_EN
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
`endif

  logic          do_push;
  logic          do_pop;
  logic          stall;
  logic          mem_we;
  logic [SW-1:0] sp_rd;

  // push and pop together is illegal: no stack motion, only the load applies
  assign do_push = bus.push & ~bus.pop;
  assign do_pop  = bus.pop & ~bus.push;
  assign sp_rd   = sp_q - SW'(1);

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    stk0_d  = stk0_q;
    stk1_d  = stk1_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    mem_we  = 1'b0;
    stall   = 1'b0;
`ifdef DSTK_GUARD_EN
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (do_push && depth_q == FULL) begin
      ovf_d = 1'b1;
      stall = 1'b1;
    end
    if (do_pop && depth_q == '0) begin
      udf_d = 1'b1;
      stall = 1'b1;
    end
`endif
    if (!stall) begin
      if (bus.load) stk0_d = bus.data_in;
      if (do_push) begin
        mem_we = 1'b1;
        stk1_d = stk0_q;
        sp_d   = sp_q + SW'(1);
        if (depth_q != FULL) depth_d = depth_q + DW'(1);
      end else if (do_pop) begin
        if (!bus.load) stk0_d = stk1_q;
        // push-write and pop-read never share a cycle, so the raw RAM read needs no bypass
        stk1_d = mem[sp_rd];
        sp_d   = sp_rd;
        if (depth_q != '0) depth_d = depth_q - DW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk0_q  <= '0;
      stk1_q  <= '0;
      sp_q    <= '0;
      depth_q <= '0;
    end else begin
      stk0_q  <= stk0_d;
      stk1_q  <= stk1_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

`ifdef DSTK_GUARD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
`endif

  // NOTE: the spill RAM is deliberately not reset; its contents are undefined until pushed.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[sp_q] <= stk1_q;
  end

  assign bus.stk0  = stk0_q;
  assign bus.stk1  = stk1_q;
  assign bus.depth = depth_q;
`ifdef DSTK_GUARD_EN
  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`else
  assign bus.ovf = 1'b0;
  assign bus.udf = 1'b0;
`endif
endmodule

// File: tb/tb_data_stack.sv
// Bench for data_stack: directed scenarios plus a random run against a queue-based stack model.
module tb_data_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int FULL  = DEPTH + 2;
  localparam int DW    = $clog2(DEPTH + 3);
`ifdef DSTK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // model: q[0] is top of stack, only valid entries are kept
  logic [WIDTH-1:0] q [$];
  bit ovf_m, udf_m;

  task automatic idle();
    bus.data_in = '0;
    bus.load    = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
  endtask

  // one clock of stimulus, then the model advances by the stack rules
  task automatic do_op(input bit p, input bit o, input bit l, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] nv;
    bus.push = p; bus.pop = o; bus.load = l; bus.data_in = d;
    @(posedge clk);
    #1;
    idle();
    if (p && !o) begin
      if (GUARD && q.size() == FULL) ovf_m = 1'b1;
      else begin
        nv = l ? d : ((q.size() > 0) ? q[0] : d);
        q.push_front(nv);
        if (q.size() > FULL) void'(q.pop_back());
      end
    end else if (o && !p) begin
      if (GUARD && q.size() == 0) udf_m = 1'b1;
      else if (q.size() > 0) begin
        void'(q.pop_front());
        if (l && q.size() > 0) q[0] = d;
      end
    end else if (l && q.size() > 0) q[0] = d;
  endtask

  task automatic test_reset();
    do_reset();
    do_op(1, 0, 1, 16'h00A5);
    do_op(1, 0, 1, 16'h1234);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.stk0 !== '0) begin bad++; $display("FAIL reset_stk0: got %h expected 0000", bus.stk0); end
    total++; if (bus.stk1 !== '0) begin bad++; $display("FAIL reset_stk1: got %h expected 0000", bus.stk1); end
    total++; if (bus.depth !== '0) begin bad++; $display("FAIL reset_depth: got %0d expected 0", bus.depth); end
    total++; if (bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got ovf=%b udf=%b expected 0 0", bus.ovf, bus.udf);
    end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_push_pop();
    do_reset();
    do_op(1, 0, 1, 16'h00A5);
    do_op(1, 0, 1, 16'h1234);
    do_op(1, 0, 1, 16'hBEEF);
    total++; if (bus.stk0 !== 16'hBEEF) begin bad++; $display("FAIL push_stk0: got %h expected beef", bus.stk0); end
    total++; if (bus.stk1 !== 16'h1234) begin bad++; $display("FAIL push_stk1: got %h expected 1234", bus.stk1); end
    total++; if (bus.depth !== DW'(3)) begin bad++; $display("FAIL push_depth: got %0d expected 3", bus.depth); end
    do_op(0, 1, 0, '0);
    do_op(0, 1, 0, '0);
    total++; if (bus.stk0 !== 16'h00A5) begin bad++; $display("FAIL pop_stk0: got %h expected 00a5", bus.stk0); end
    total++; if (bus.depth !== DW'(1)) begin bad++; $display("FAIL pop_depth: got %0d expected 1", bus.depth); end
  endtask

  task automatic test_spill();
    do_reset();
    for (int i = 1; i <= FULL; i++) do_op(1, 0, 1, WIDTH'(i));
    total++; if (bus.depth !== DW'(FULL)) begin bad++; $display("FAIL spill_depth: got %0d expected %0d", bus.depth, FULL); end
    total++; if (bus.stk0 !== WIDTH'(FULL)) begin bad++; $display("FAIL spill_stk0: got %0d expected %0d", bus.stk0, FULL); end
    total++; if (bus.stk1 !== WIDTH'(FULL - 1)) begin bad++; $display("FAIL spill_stk1: got %0d expected %0d", bus.stk1, FULL - 1); end
    for (int j = 1; j <= FULL - 1; j++) begin
      do_op(0, 1, 0, '0);
      total++;
      if (bus.stk0 !== WIDTH'(FULL - j)) begin
        bad++; $display("FAIL spill_lifo pop%0d: got %0d expected %0d", j, bus.stk0, FULL - j);
      end
    end
    total++; if (bus.depth !== DW'(1)) begin bad++; $display("FAIL spill_drain_depth: got %0d expected 1", bus.depth); end
  endtask

  task automatic test_binary_op();
    do_reset();
    do_op(1, 0, 1, 16'd3);
    do_op(1, 0, 1, 16'd5);
    do_op(0, 1, 1, 16'd8);
    total++; if (bus.stk0 !== 16'd8) begin bad++; $display("FAIL binop_stk0: got %h expected 0008", bus.stk0); end
    total++; if (bus.depth !== DW'(1)) begin bad++; $display("FAIL binop_depth: got %0d expected 1", bus.depth); end
    do_op(0, 0, 1, 16'hFFF7);
    total++; if (bus.stk0 !== 16'hFFF7) begin bad++; $display("FAIL load_stk0: got %h expected fff7", bus.stk0); end
    total++; if (bus.depth !== DW'(1)) begin bad++; $display("FAIL load_depth: got %0d expected 1", bus.depth); end
  endtask

  task automatic test_illegal();
    do_reset();
    for (int i = 1; i <= 4; i++) do_op(1, 0, 1, WIDTH'(i));
    do_op(1, 1, 1, 16'h7777);
    total++; if (bus.stk0 !== 16'h7777) begin bad++; $display("FAIL illegal_stk0: got %h expected 7777", bus.stk0); end
    total++; if (bus.stk1 !== 16'd3) begin bad++; $display("FAIL illegal_stk1: got %h expected 0003", bus.stk1); end
    total++; if (bus.depth !== DW'(4)) begin bad++; $display("FAIL illegal_depth: got %0d expected 4", bus.depth); end
    do_op(1, 1, 0, 16'h1111);
    total++; if (bus.stk0 !== 16'h7777 || bus.depth !== DW'(4)) begin
      bad++; $display("FAIL illegal_noload: got stk0=%h depth=%0d expected 7777 4", bus.stk0, bus.depth);
    end
  endtask

  task automatic test_guard();
    logic [WIDTH-1:0] old0, old1;
    do_reset();
    for (int i = 0; i < FULL; i++) do_op(1, 0, 1, WIDTH'($urandom));
    old0 = q[0];
    old1 = q[1];
    do_op(1, 0, 1, 16'hC0DE);
`ifdef DSTK_GUARD_EN
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL guard_ovf: got %b expected 1", bus.ovf); end
    total++; if (bus.stk0 !== old0 || bus.stk1 !== old1 || bus.depth !== DW'(FULL)) begin
      bad++; $display("FAIL guard_ovf_hold: got %h %h %0d expected %h %h %0d",
                      bus.stk0, bus.stk1, bus.depth, old0, old1, FULL);
    end
    do_op(0, 1, 0, '0);
    total++; if (bus.stk0 !== old1 || bus.ovf !== 1'b1) begin
      bad++; $display("FAIL guard_ovf_after_pop: got stk0=%h ovf=%b expected %h 1", bus.stk0, bus.ovf, old1);
    end
    do_reset();
    do_op(0, 1, 1, 16'h5555);
    total++; if (bus.udf !== 1'b1 || bus.ovf !== 1'b0) begin
      bad++; $display("FAIL guard_udf: got udf=%b ovf=%b expected 1 0", bus.udf, bus.ovf);
    end
    total++; if (bus.depth !== '0 || bus.stk0 !== '0) begin
      bad++; $display("FAIL guard_udf_hold: got depth=%0d stk0=%h expected 0 0000", bus.depth, bus.stk0);
    end
`else
    total++; if (bus.depth !== DW'(FULL) || bus.ovf !== 1'b0) begin
      bad++; $display("FAIL wrap_depth: got depth=%0d ovf=%b expected %0d 0", bus.depth, bus.ovf, FULL);
    end
    total++; if (bus.stk0 !== 16'hC0DE || bus.stk1 !== old0) begin
      bad++; $display("FAIL wrap_regs: got %h %h expected c0de %h", bus.stk0, bus.stk1, old0);
    end
    while (q.size() > 1) begin
      do_op(0, 1, 0, '0);
      total++;
      if (bus.stk0 !== q[0]) begin bad++; $display("FAIL wrap_drain: got %h expected %h", bus.stk0, q[0]); end
    end
`endif
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 6);
      if (q.size() == 0 && r != 0 && r != 2) r = 2;
      if (GUARD && q.size() == FULL && (r == 2 || r == 3)) r = 5;
      case (r)
        0: do_op(0, 0, 0, WIDTH'($urandom));
        1: do_op(0, 0, 1, WIDTH'($urandom));
        2: do_op(1, 0, 1, WIDTH'($urandom));
        3: do_op(1, 0, 0, WIDTH'($urandom));
        4: do_op(0, 1, 1, WIDTH'($urandom));
        5: do_op(0, 1, 0, WIDTH'($urandom));
        default: do_op(1, 1, 1'($urandom), WIDTH'($urandom));
      endcase
      total++; if (bus.depth !== DW'(q.size())) begin
        bad++; $display("FAIL rand_depth op%0d: got %0d expected %0d", i, bus.depth, q.size());
      end
      if (q.size() >= 1) begin
        total++; if (bus.stk0 !== q[0]) begin bad++; $display("FAIL rand_stk0 op%0d: got %h expected %h", i, bus.stk0, q[0]); end
      end
      if (q.size() >= 2) begin
        total++; if (bus.stk1 !== q[1]) begin bad++; $display("FAIL rand_stk1 op%0d: got %h expected %h", i, bus.stk1, q[1]); end
      end
      total++; if (bus.ovf !== ovf_m || bus.udf !== udf_m) begin
        bad++; $display("FAIL rand_flags op%0d: got ovf=%b udf=%b expected %b %b", i, bus.ovf, bus.udf, ovf_m, udf_m);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_push_pop();
    test_spill();
    test_binary_op();
    test_illegal();
    test_guard();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
